// File: rtl/ling_accum32.sv
// ling_accum32: streaming 32-bit packet accumulator on a sparse-4 Ling adder.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last
//        input stream; out_valid/out_ready/out_sum/out_count/out_carry/
//        out_ovf result handshake and sticky flags. MAX_TERMS: 1..255.

// J32_node_adder: carry-less 32-bit Ling adder, s = a + b mod 2^32.
// Ports: a, b operands; s sum.
module J32_node_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    // Ling pseudo-carry H[i] = g[i] | t[i-1] & H[i-1]; real carry out of
    // bit i is t[i] & H[i]. Prefix is resolved only at every 4th bit
    // (Kogge-Stone over 8 nibble groups), then filled in inside each nibble.
    function automatic logic [31:0] ling_sum(
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [31:0] g, t, p, eg, et, lg, lt, h;
        logic [7:0]  bg, bt;
        g  = x & y;
        t  = x | y;
        p  = x ^ y;
        eg = g;
        et = {t[30:0], 1'b0};
        for (int k = 0; k < 8; k++) begin
            lg[4*k] = eg[4*k];
            lt[4*k] = et[4*k];
            for (int j = 1; j < 4; j++) begin
                lg[4*k+j] = eg[4*k+j] | (et[4*k+j] & lg[4*k+j-1]);
                lt[4*k+j] = et[4*k+j] & lt[4*k+j-1];
            end
            bg[k] = lg[4*k+3];
            bt[k] = lt[4*k+3];
        end
        // Descending k keeps level-d operands from the previous level.
        for (int d = 1; d < 8; d = d * 2) begin
            for (int k = 7; k >= 0; k--) begin
                if (k >= d) begin
                    bg[k] = bg[k] | (bt[k] & bg[k-d]);
                    bt[k] = bt[k] & bt[k-d];
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k == 0) begin
                    h[4*k+j] = lg[4*k+j];
                end else begin
                    h[4*k+j] = lg[4*k+j] | (lt[4*k+j] & bg[k-1]);
                end
            end
        end
        return p ^ {t[30:0] & h[30:0], 1'b0};
    endfunction

    assign s = ling_sum(a, b);

endmodule

module ling_accum32 #(
    parameter int MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic [7:0]  out_count,
    output logic        out_carry,
    output logic        out_ovf
);

    localparam logic       ACCUM = 1'b0;
    localparam logic       HOLD  = 1'b1;
    localparam logic [7:0] MAX_C = 8'(MAX_TERMS);

    logic        state;
    logic [31:0] acc;
    logic [7:0]  cnt;
    logic        carry_f;
    logic        ovf_f;

    logic [31:0] s;
    logic [7:0]  cnt_inc;
    logic        cout;
    logic        ovf;
    logic        accept;
    logic        close;

    J32_node_adder u_add (
        .a (acc),
        .b (in_data),
        .s (s)
    );

    // The adder has no carry-out, so both flags are rebuilt from bit 31.
    assign cout = (acc[31] & in_data[31])
                | ((acc[31] ^ in_data[31]) & ~s[31]);
    assign ovf  = (acc[31] == in_data[31]) & (s[31] != acc[31]);

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign cnt_inc   = cnt + 8'd1;
    assign close     = in_last | (cnt_inc == MAX_C);

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_carry = carry_f;
    assign out_ovf   = ovf_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            carry_f <= 1'b0;
            ovf_f   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc     <= s;
                        cnt     <= cnt_inc;
                        carry_f <= carry_f | cout;
                        ovf_f   <= ovf_f | ovf;
                        if (close) state <= HOLD;
                    end
                end
                default: begin
                    if (out_ready) begin
                        acc     <= '0;
                        cnt     <= '0;
                        carry_f <= 1'b0;
                        ovf_f   <= 1'b0;
                        state   <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule
